// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_MIN_RATIO = 2;
  localparam int DIV_RST_CNT   = 1;
  localparam int DIV_W_DEFAULT = 8;

  typedef enum logic {
    CH_BYPASS = 1'b0,
    CH_DIVIDE = 1'b1
  } ch_mode_e;

endpackage

// File: rtl/clk_div_ch.sv
// Single divider channel: integer ratio divider with a bypass mux.
// Optional rise strobe output enabled by CLK_DIV_MULTI_PULSE_EN.
//
// mode      | meaning
// CH_BYPASS | en low or ratio < 2: clock passes through, counters held
// CH_DIVIDE | divided clock driven from div_q
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_ref_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] ratio_i,
  output logic             div_clk_o,
  output logic [DIV_W-1:0] ratio_act_o
`ifdef CLK_DIV_MULTI_PULSE_EN
  ,
  output logic             rise_pulse_o
`endif
);

  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [DIV_W-1:0] phase_len;
  logic             phase_done;
  ch_mode_e         mode;

  // Mode decode and phase length; high phase takes the extra cycle of odd ratios.
  always_comb begin
    mode       = (en_i && (act_q >= DIV_W'(DIV_MIN_RATIO))) ? CH_DIVIDE : CH_BYPASS;
    phase_len  = div_q ? ((act_q >> 1) + {{(DIV_W-1){1'b0}}, act_q[0]}) : (act_q >> 1);
    phase_done = (cnt_q >= phase_len);
  end

  // Next-state: count within a phase, toggle at phase end, reload ratio only at period end.
  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    div_d = div_q;
    if (mode == CH_BYPASS) begin
      act_d = ratio_i;
      cnt_d = DIV_W'(DIV_RST_CNT);
      div_d = 1'b0;
    end else if (phase_done) begin
      div_d = ~div_q;
      cnt_d = DIV_W'(DIV_RST_CNT);
      if (div_q) act_d = ratio_i;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_ref_i) begin
    if (rst_i) begin
      act_q <= '0;
      cnt_q <= DIV_W'(DIV_RST_CNT);
      div_q <= 1'b0;
    end else begin
      act_q <= act_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

`ifdef CLK_DIV_MULTI_PULSE_EN
  logic pulse_q;

  // Strobe registered alongside the low->high toggle so it aligns with the first high cycle.
  always_ff @(posedge clk_ref_i) begin
    if (rst_i) pulse_q <= 1'b0;
    else       pulse_q <= (mode == CH_DIVIDE) && phase_done && !div_q;
  end

  assign rise_pulse_o = pulse_q;
`endif

  assign div_clk_o   = (mode == CH_DIVIDE) ? div_q : clk_ref_i;
  assign ratio_act_o = act_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider top: slices the ratio bus and instantiates
// one clk_div_ch per channel. Optional rise strobe port: CLK_DIV_MULTI_PULSE_EN.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic                    i_clk_ref,
  input  logic                    i_rst,
  input  logic [NUM_CH-1:0]       i_clk_en,
  input  logic [NUM_CH*DIV_W-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]       o_div_clk,
  output logic [NUM_CH*DIV_W-1:0] o_ratio_act
`ifdef CLK_DIV_MULTI_PULSE_EN
  ,
  output logic [NUM_CH-1:0]       o_rise_pulse
`endif
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk_ref_i   (i_clk_ref),
      .rst_i       (i_rst),
      .en_i        (i_clk_en[k]),
      .ratio_i     (i_div_ratio[k*DIV_W +: DIV_W]),
      .div_clk_o   (o_div_clk[k]),
      .ratio_act_o (o_ratio_act[k*DIV_W +: DIV_W])
`ifdef CLK_DIV_MULTI_PULSE_EN
      ,
      .rise_pulse_o(o_rise_pulse[k])
`endif
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int DW  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NCH-1:0]     en;
  logic [NCH*DW-1:0]  ratio;
  logic [NCH-1:0]     div_clk;
  logic [NCH*DW-1:0]  ratio_act;
`ifdef CLK_DIV_MULTI_PULSE_EN
  logic [NCH-1:0]     rise_pulse;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  clk_div_multi #(.NUM_CH(NCH), .DIV_W(DW)) dut (
    .i_clk_ref  (clk),
    .i_rst      (rst),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (div_clk),
    .o_ratio_act(ratio_act)
`ifdef CLK_DIV_MULTI_PULSE_EN
    ,
    .o_rise_pulse(rise_pulse)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel is a position within a period of length R.
  // Low for positions [0, R/2), high for [R/2, R). Ratio is reloaded at period end
  // and continuously while bypassed.
  int  m_act [NCH];
  int  m_pos [NCH];
  bit  m_pls [NCH];

  initial for (int k = 0; k < NCH; k++) begin m_act[k] = 0; m_pos[k] = 0; m_pls[k] = 0; end

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      bit dv;
      dv = en[k] && (m_act[k] >= 2);
      m_pls[k] = 1'b0;
      if (rst) begin
        m_act[k] = 0; m_pos[k] = 0;
      end else if (!dv) begin
        m_act[k] = int'(ratio[k*DW +: DW]); m_pos[k] = 0;
      end else if (m_pos[k] == m_act[k] - 1) begin
        m_pos[k] = 0; m_act[k] = int'(ratio[k*DW +: DW]);
      end else begin
        m_pos[k] = m_pos[k] + 1;
        m_pls[k] = (m_pos[k] == m_act[k] / 2);
      end
    end
  end

  task automatic cmp_all(input bit lvl);
    for (int k = 0; k < NCH; k++) begin
      bit dv;
      int e;
      dv = en[k] && (m_act[k] >= 2);
      e  = dv ? int'(m_pos[k] >= m_act[k] / 2) : int'(lvl);
      chk($sformatf("div_clk[%0d]", k), int'(div_clk[k]), e);
      chk($sformatf("ratio_act[%0d]", k), int'(ratio_act[k*DW +: DW]), m_act[k]);
`ifdef CLK_DIV_MULTI_PULSE_EN
      chk($sformatf("rise_pulse[%0d]", k), int'(rise_pulse[k]), int'(m_pls[k]));
`endif
    end
  endtask

  // Compare on both clock levels so bypass pass-through is observed.
  always begin
    @(posedge clk); #2;
    if (chk_en) cmp_all(1'b1);
    @(negedge clk); #2;
    if (chk_en) cmp_all(1'b0);
  end

  task automatic smp(input int ch, output logic v);
    @(posedge clk); #3;
    v = div_clk[ch];
  endtask

  task automatic set_ratio(input int ch, input int r);
    ratio[ch*DW +: DW] = DW'(r);
  endtask

  // Wait for a falling edge, then measure one low and one high phase in cycles.
  task automatic measure(input int ch, input int elo, input int ehi, input string nm);
    logic prev, cur;
    int lo, hi, g;
    smp(ch, prev);
    g = 0;
    forever begin
      smp(ch, cur);
      if (prev === 1'b1 && cur === 1'b0) break;
      prev = cur;
      g++;
      if (g > 1200) break;
    end
    if (g > 1200) begin
      chk({nm, "_fall_timeout"}, 1, 0);
    end else begin
      lo = 1;
      forever begin smp(ch, cur); if (cur !== 1'b0 || lo > 600) break; lo++; end
      hi = 1;
      forever begin smp(ch, cur); if (cur !== 1'b1 || hi > 600) break; hi++; end
      chk({nm, "_low"}, lo, elo);
      chk({nm, "_high"}, hi, ehi);
    end
  endtask

  task automatic wait_high(input int ch, input string nm);
    logic v;
    int g;
    g = 0;
    do begin smp(ch, v); g++; end while (v !== 1'b1 && g < 600);
    if (v !== 1'b1) chk({nm, "_high_timeout"}, 1, 0);
  endtask

  initial begin
    logic v;
    rst = 1'b1; en = '0; ratio = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #3;
    chk("rst_ratio_act", int'(ratio_act), 0);

    // ratio 4 on channel 0
    set_ratio(0, 4); en[0] = 1'b1; rst = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    chk("r4_act", int'(ratio_act[0 +: DW]), 4);
    measure(0, 2, 2, "r4");

    // ratio 5
    set_ratio(0, 5);
    measure(0, 2, 3, "r5");

    // 6 then 3 written mid-high-phase
    set_ratio(0, 6);
    measure(0, 3, 3, "r6");
    wait_high(0, "r6b");
    set_ratio(0, 3);
    chk("r6_mid_act", int'(ratio_act[0 +: DW]), 6);
    measure(0, 1, 2, "r3");
    chk("r3_act", int'(ratio_act[0 +: DW]), 3);

    // ratio 1 -> bypass
    set_ratio(0, 1);
    repeat (8) @(posedge clk);
    @(negedge clk); #2;
    chk("byp1_low", int'(div_clk[0]), 0);
    @(posedge clk); #2;
    chk("byp1_high", int'(div_clk[0]), 1);

    // enable off, ratio 0, then re-enable with ratio 2
    en[0] = 1'b0; set_ratio(0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("byp0_act", int'(ratio_act[0 +: DW]), 0);
    set_ratio(0, 2); en[0] = 1'b1;
    smp(0, v); chk("r2_first_low", int'(v), 0);
    smp(0, v); chk("r2_then_high", int'(v), 1);
    measure(0, 1, 1, "r2");

    // four channels concurrently
    set_ratio(1, 3); set_ratio(2, 7); set_ratio(3, 255);
    en = 4'hF;
    measure(3, 127, 128, "c3_r255");
    chk("c_act3", int'(ratio_act[3*DW +: DW]), 255);
    chk("c_act2", int'(ratio_act[2*DW +: DW]), 7);
    measure(2, 3, 4, "c2_r7");
    measure(1, 1, 2, "c1_r3");
    measure(0, 1, 1, "c0_r2");

    // reset mid-high-phase on channel 3
    wait_high(3, "rst3");
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst_mid_act", int'(ratio_act), 0);
    chk("rst_mid_byp_high", int'(div_clk[3]), 1);
    @(negedge clk); #2;
    chk("rst_mid_byp_low", int'(div_clk[3]), 0);
    rst = 1'b0;
    measure(1, 1, 2, "post_rst_c1");

    repeat (4) @(posedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
